// File: rtl/song_sequencer.sv
// song_sequencer: autoplay note sequencer. On start it walks one of eight
// songs held in an internal ROM. Each entry is {note[7:4], dur[3:0]}. The
// entry's note sounds for dur ticks, followed by GAP_TICKS silent ticks.
// An entry with dur == 0 marks the end of a song. A song without a marker
// ends after entry MAX_LEN-1.
// Optional feature macro: SEQ_LOOP_EN. When it is defined, the song restarts
// from entry 0 after every end, and only stop or rst ends playback.
// The ROM tables assume MAX_LEN >= 16.
module song_sequencer #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 8,
    parameter int GAP_TICKS = 1,
    parameter int MAX_LEN   = 64,
    localparam int IW       = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [2:0]    song_select,
    output logic [3:0]    note,
    output logic          note_on,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] index
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    // The counter must cover the longest dwell: a full 15-tick note or the gap.
    localparam int LONGEST  = (GAP_TICKS > 15) ? GAP_TICKS : 15;
    localparam int CW       = $clog2(LONGEST * TICK_DIV + 1);

    localparam logic [CW-1:0] TICK_DIV_C = CW'(TICK_DIV);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_TICKS * TICK_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(MAX_LEN - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [2:0]    song_q, song_d;
    logic [IW-1:0] index_q, index_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    dur_q, dur_d;
    logic [3:0]    note_q, note_d;
    logic          note_on_q, note_on_d;
    logic [7:0]    rom_q, rom_d;
    logic [CW-1:0] play_last;
    logic          advance;

    // Song table. Song 6 has no end marker, so it runs through all MAX_LEN
    // entries. Song 7 is the fixed test pattern.
    function automatic logic [7:0] rom_entry(input logic [2:0] song, input logic [IW-1:0] idx);
        logic [7:0] e;
        e = 8'h00;
        case (song)
            3'd0: case (idx)
                IW'(0): e = 8'h12;  IW'(1): e = 8'h22;  IW'(2): e = 8'h32;
                IW'(3): e = 8'h42;  IW'(4): e = 8'h52;  IW'(5): e = 8'h62;
                IW'(6): e = 8'h72;  IW'(7): e = 8'h84;
                default: e = 8'h00;
            endcase
            3'd1: case (idx)
                IW'(0): e = 8'h54;  IW'(1): e = 8'h02;  IW'(2): e = 8'h54;
                IW'(3): e = 8'h02;  IW'(4): e = 8'h38;
                default: e = 8'h00;
            endcase
            3'd2: case (idx)
                IW'(0): e = 8'h81;  IW'(1): e = 8'h71;  IW'(2): e = 8'h61;
                IW'(3): e = 8'h51;  IW'(4): e = 8'h41;  IW'(5): e = 8'h31;
                IW'(6): e = 8'h21;  IW'(7): e = 8'h18;
                default: e = 8'h00;
            endcase
            3'd3: case (idx)
                IW'(0): e = 8'hA2;  IW'(1): e = 8'hC2;  IW'(2): e = 8'hE4;
                IW'(3): e = 8'h01;  IW'(4): e = 8'hE2;  IW'(5): e = 8'hC2;
                IW'(6): e = 8'hA4;
                default: e = 8'h00;
            endcase
            3'd4: case (idx)
                IW'(0): e = 8'h3F;
                default: e = 8'h00;
            endcase
            3'd5: case (idx)
                IW'(0): e = 8'h11;  IW'(1): e = 8'h91;  IW'(2): e = 8'h11;
                IW'(3): e = 8'h91;
                default: e = 8'h00;
            endcase
            3'd6: e = {4'(idx), 4'h1};
            default: case (idx)
                IW'(0): e = 8'h12;  IW'(1): e = 8'h01;  IW'(2): e = 8'hF1;
                default: e = 8'h00;
            endcase
        endcase
        return e;
    endfunction

    // Next-state logic. The ROM is addressed with the next song/index, so
    // the registered entry is ready during the FETCH cycle.
    always_comb begin
        state_d   = state_q;
        song_d    = song_q;
        index_d   = index_q;
        cnt_d     = cnt_q + CW'(1);
        dur_d     = dur_q;
        note_d    = note_q;
        note_on_d = note_on_q;
        advance   = 1'b0;
        play_last = CW'(dur_q) * TICK_DIV_C - CW'(1);

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start && !stop) begin
                    state_d = S_FETCH;
                    song_d  = song_select;
                    index_d = '0;
                end
            end
            S_FETCH: begin
                if (rom_q[3:0] == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    state_d   = S_PLAY;
                    dur_d     = rom_q[3:0];
                    note_d    = rom_q[7:4];
                    note_on_d = (rom_q[7:4] != 4'd0);
                end
            end
            S_PLAY: begin
                if (cnt_q == play_last) begin
                    if (GAP_TICKS > 0) begin
                        state_d   = S_GAP;
                        note_on_d = 1'b0;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    advance = 1'b1;
                end
            end
            S_DONE: begin
`ifdef SEQ_LOOP_EN
                state_d = S_FETCH;
                index_d = '0;
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (index_q == LAST_IDX) begin
                state_d = S_DONE;
            end else begin
                index_d = index_q + IW'(1);
                state_d = S_FETCH;
            end
        end

        // DONE presents silence for its single cycle.
        if (state_d == S_DONE) begin
            note_d    = 4'd0;
            note_on_d = 1'b0;
        end

        // Abort takes priority over everything, with no done pulse.
        if (stop && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            note_d    = 4'd0;
            note_on_d = 1'b0;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        rom_d = rom_entry(song_d, index_d);
    end

    // State, datapath and ROM output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            song_q    <= '0;
            index_q   <= '0;
            cnt_q     <= '0;
            dur_q     <= '0;
            note_q    <= '0;
            note_on_q <= 1'b0;
            rom_q     <= '0;
        end else begin
            state_q   <= state_d;
            song_q    <= song_d;
            index_q   <= index_d;
            cnt_q     <= cnt_d;
            dur_q     <= dur_d;
            note_q    <= note_d;
            note_on_q <= note_on_d;
            rom_q     <= rom_d;
        end
    end

    assign note    = note_q;
    assign note_on = note_on_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign index   = index_q;

endmodule
